// File: rtl/d_cache_wt.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate data cache.
// CPU side and memory side are both sram-like request/addr_ok/data_ok ports.
// kseg1 (addr[31:29] == 3'b101) bypasses the array entirely.
module d_cache_wt #(
  parameter int unsigned INDEX_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int unsigned Lines = 2 ** INDEX_WIDTH;
  localparam int unsigned TagW  = 30 - INDEX_WIDTH;

  typedef enum logic [1:0] {StIdle, StLookup, StMemReq, StMemWait} state_e;

  state_e state_q, state_d;

  // Latched request
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Line storage; only the valid bits need a reset
  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TagW-1:0]        req_tag;
  logic                   cached;
  logic                   hit;
  logic [31:0]            line_data;
  logic [3:0]             byte_mask;
  logic [31:0]            merged;
  logic                   accept;
  logic                   mem_done;
  logic                   write_hit;
  logic                   fill;

  assign idx       = addr_q[INDEX_WIDTH+1:2];
  assign req_tag   = addr_q[31:INDEX_WIDTH+2];
  assign cached    = (addr_q[31:29] != 3'b101);
  assign line_data = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == req_tag) && cached;

  assign accept    = cpu_data_req && (state_q == StIdle) && !rst;
  // A same-cycle addr_ok/data_ok in StMemReq completes just like StMemWait
  assign mem_done  = ((state_q == StMemWait) && mem_data_ok) ||
                     ((state_q == StMemReq) && mem_addr_ok && mem_data_ok);
  assign write_hit = !rst && (state_q == StLookup) && hit && wr_q;
  assign fill      = !rst && mem_done && !wr_q && cached;

  // Byte-lane mask of the latched store; size 3 behaves as word
  always_comb begin
    byte_mask = 4'b1111;
    unique case (size_q)
      2'd0:    byte_mask = 4'b0001 << addr_q[1:0];
      2'd1:    byte_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  end

  // Merge store data into the resident line under the byte mask
  always_comb begin
    merged = line_data;
    for (int b = 0; b < 4; b++) begin
      if (byte_mask[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StLookup;
      StLookup:  state_d = (hit && !wr_q) ? StIdle : StMemReq;
      StMemReq:  begin
        if (mem_done)         state_d = StIdle;
        else if (mem_addr_ok) state_d = StMemWait;
      end
      StMemWait: if (mem_data_ok) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Capture the CPU request on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      wr_q    <= cpu_data_wr;
      size_q  <= cpu_data_size;
      addr_q  <= cpu_data_addr;
      wdata_q <= cpu_data_wdata;
    end
  end

  // Valid bits: cleared by reset, set on a cached-read fill
  always_ff @(posedge clk) begin
    if (rst)       valid_q      <= '0;
    else if (fill) valid_q[idx] <= 1'b1;
  end

  // Tag/data array: write-hit merge or read-miss fill (mutually exclusive by state)
  always_ff @(posedge clk) begin
    if (write_hit) begin
      data_q[idx] <= merged;
    end else if (fill) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= mem_rdata;
    end
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = 32'd0;
    mem_req          = 1'b0;
    mem_wr           = 1'b0;
    mem_size         = 2'd0;
    mem_addr         = 32'd0;
    mem_wdata        = 32'd0;
    if (!rst) begin
      unique case (state_q)
        StIdle:   cpu_data_addr_ok = cpu_data_req;
        StLookup: begin
          if (hit && !wr_q) begin
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = line_data;
          end
        end
        StMemReq: begin
          mem_req   = 1'b1;
          mem_wdata = wdata_q;
          if (cached && !wr_q) begin
            mem_size = 2'd2;
            mem_addr = {addr_q[31:2], 2'b00};
          end else begin
            mem_wr   = wr_q;
            mem_size = size_q;
            mem_addr = addr_q;
          end
          if (mem_done) begin
            cpu_data_data_ok = 1'b1;
            if (!wr_q) cpu_data_rdata = mem_rdata;
          end
        end
        StMemWait: begin
          if (mem_data_ok) begin
            cpu_data_data_ok = 1'b1;
            if (!wr_q) cpu_data_rdata = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_wt.sv
// Directed bench for d_cache_wt; the bench plays both the CPU and the memory bridge.
module tb_d_cache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  d_cache_wt dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_data_req     (cpu_data_req),
    .cpu_data_wr      (cpu_data_wr),
    .cpu_data_size    (cpu_data_size),
    .cpu_data_addr    (cpu_data_addr),
    .cpu_data_wdata   (cpu_data_wdata),
    .cpu_data_rdata   (cpu_data_rdata),
    .cpu_data_addr_ok (cpu_data_addr_ok),
    .cpu_data_data_ok (cpu_data_data_ok),
    .mem_req          (mem_req),
    .mem_wr           (mem_wr),
    .mem_size         (mem_size),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_addr_ok      (mem_addr_ok),
    .mem_data_ok      (mem_data_ok)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU transaction. For a hit, ret is the expected load data; for a miss,
  // ret is what the memory returns (and therefore the expected load data).
  // same=1 makes memory raise addr_ok and data_ok together.
  task automatic xact(input string tag, input logic wr, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic hit,
                      input logic [31:0] exp_maddr, input logic [1:0] exp_msize,
                      input logic [31:0] ret, input logic same);
    @(negedge clk);
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    #1;
    check_eq({tag, ".addr_ok"}, 32'(cpu_data_addr_ok), 32'd1);
    @(negedge clk);
    cpu_data_req = 1'b0;
    #1;
    if (hit) begin
      check_eq({tag, ".hit_data_ok"}, 32'(cpu_data_data_ok), 32'd1);
      check_eq({tag, ".hit_rdata"}, cpu_data_rdata, ret);
      check_eq({tag, ".hit_no_mem_req"}, 32'(mem_req), 32'd0);
    end else begin
      check_eq({tag, ".lookup_data_ok"}, 32'(cpu_data_data_ok), 32'd0);
      @(negedge clk);
      #1;
      check_eq({tag, ".mem_req"}, 32'(mem_req), 32'd1);
      check_eq({tag, ".mem_addr"}, mem_addr, exp_maddr);
      check_eq({tag, ".mem_size"}, 32'(mem_size), 32'(exp_msize));
      check_eq({tag, ".mem_wr"}, 32'(mem_wr), 32'(wr));
      if (wr) check_eq({tag, ".mem_wdata"}, mem_wdata, wdata);
      mem_addr_ok = 1'b1;
      if (same) begin
        mem_data_ok = 1'b1;
        mem_rdata   = ret;
        #1;
        check_eq({tag, ".same_data_ok"}, 32'(cpu_data_data_ok), 32'd1);
        if (!wr) check_eq({tag, ".same_rdata"}, cpu_data_rdata, ret);
      end
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (!same) begin
        #1;
        check_eq({tag, ".wait_no_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, ".wait_data_ok0"}, 32'(cpu_data_data_ok), 32'd0);
        mem_data_ok = 1'b1;
        mem_rdata   = ret;
        #1;
        check_eq({tag, ".data_ok"}, 32'(cpu_data_data_ok), 32'd1);
        if (!wr) check_eq({tag, ".rdata"}, cpu_data_rdata, ret);
        @(negedge clk);
        mem_data_ok = 1'b0;
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    cpu_data_req   = 1'b1;
    cpu_data_wr    = 1'b0;
    cpu_data_size  = 2'd2;
    cpu_data_addr  = 32'h8000_0000;
    cpu_data_wdata = 32'd0;
    mem_rdata      = 32'd0;
    mem_addr_ok    = 1'b0;
    mem_data_ok    = 1'b0;

    // Reset: outputs low even with a pending CPU request
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst.addr_ok", 32'(cpu_data_addr_ok), 32'd0);
    check_eq("rst.data_ok", 32'(cpu_data_data_ok), 32'd0);
    check_eq("rst.mem_req", 32'(mem_req), 32'd0);
    check_eq("rst.mem_addr", mem_addr, 32'd0);
    cpu_data_req = 1'b0;
    rst          = 1'b0;

    // Stray mem_data_ok in idle is ignored
    @(negedge clk);
    mem_data_ok = 1'b1;
    #1;
    check_eq("idle.stray_data_ok", 32'(cpu_data_data_ok), 32'd0);
    mem_data_ok = 1'b0;

    // 1: load miss fills, reload hits
    xact("t1.miss", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b0, 32'h8000_0000, 2'd2,
         32'h1234_5678, 1'b0);
    xact("t1.hit", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b1, 32'd0, 2'd0, 32'h1234_5678, 1'b0);

    // 2: byte store hit writes through and merges into the line
    xact("t2.st", 1'b1, 2'd0, 32'h8000_0001, 32'h0000_AB00, 1'b0, 32'h8000_0001, 2'd0,
         32'd0, 1'b0);
    xact("t2.ld", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b1, 32'd0, 2'd0, 32'h1234_AB78, 1'b0);

    // 3: kseg1 loads always go to memory and do not disturb index 0
    xact("t3.a", 1'b0, 2'd2, 32'hBFC0_0000, 32'd0, 1'b0, 32'hBFC0_0000, 2'd2,
         32'hDEAD_BEEF, 1'b0);
    xact("t3.b", 1'b0, 2'd2, 32'hBFC0_0000, 32'd0, 1'b0, 32'hBFC0_0000, 2'd2,
         32'h0BAD_F00D, 1'b0);
    xact("t3.keep", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b1, 32'd0, 2'd0, 32'h1234_AB78, 1'b0);

    // 4: write miss does not allocate
    xact("t4.st", 1'b1, 2'd2, 32'h8000_2004, 32'hCAFE_0001, 1'b0, 32'h8000_2004, 2'd2,
         32'd0, 1'b0);
    xact("t4.ld", 1'b0, 2'd2, 32'h8000_2004, 32'd0, 1'b0, 32'h8000_2004, 2'd2,
         32'hCAFE_F00D, 1'b0);

    // 5: conflicting tag on index 0 evicts
    xact("t5.evict", 1'b0, 2'd2, 32'h8000_1000, 32'd0, 1'b0, 32'h8000_1000, 2'd2,
         32'h5555_AAAA, 1'b0);
    xact("t5.remiss", 1'b0, 2'd2, 32'h8000_0002, 32'd0, 1'b0, 32'h8000_0000, 2'd2,
         32'h1111_2222, 1'b0);
    xact("t5.rehit", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b1, 32'd0, 2'd0, 32'h1111_2222, 1'b0);

    // 6: reset while waiting on memory
    @(negedge clk);
    cpu_data_req  = 1'b1;
    cpu_data_wr   = 1'b0;
    cpu_data_addr = 32'h8000_1000;
    @(negedge clk);
    cpu_data_req = 1'b0;
    @(negedge clk);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    rst         = 1'b1;
    cpu_data_req = 1'b1;
    #1;
    check_eq("t6.rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("t6.rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
    check_eq("t6.rst_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    cpu_data_req = 1'b0;
    #1;
    check_eq("t6.idle_no_req", 32'(mem_req), 32'd0);
    // Line was valid before reset; now must miss. Memory answers in one step.
    xact("t6.miss", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b0, 32'h8000_0000, 2'd2,
         32'h7777_0000, 1'b1);
    xact("t6.hit", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b1, 32'd0, 2'd0, 32'h7777_0000, 1'b0);
    // Same-cycle handshake on a store as well
    xact("t6.st", 1'b1, 2'd1, 32'hA000_0102, 32'h5A5A_0000, 1'b0, 32'hA000_0102, 2'd1,
         32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
